// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// No logic of its own; imported by every fetch-unit file.
package pc_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DISCARD
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_JUMP
  } pc_sel_e;

  localparam logic [31:0] NOP_INST             = 32'h0000_0013;
  localparam logic [31:0] PC_INC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory port: request/address out, response valid/data back.
// Memory accepts a request in any cycle imem_req is high; the response arrives one or more cycles later.
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_next.sv
// Combinational next-PC select: hold, sequential +4, or word-aligned redirect target.
// Zero latency, no backpressure.
module pc_next
  import pc_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] jump_target,
  input  pc_sel_e     sel,
  output logic [31:0] pc_nxt
);

  always_comb begin
    pc_nxt = pc;
    case (sel)
      PC_INC:  pc_nxt = pc + PC_INC_STEP;
      PC_JUMP: pc_nxt = jump_target & 32'hFFFF_FFFC;
      default: pc_nxt = pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch unit: single outstanding request, response to output in the WAIT cycle (1 inst / 2 cycles best case).
// stall holds the outputs; one early response parks in a one-entry skid buffer; redirects flush in-flight work.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_fetch_if.master        imem,
  input  logic              pc_jump,
  input  logic [31:0]       jump_target,
  input  logic              stall,
  output logic              inst_valid,
  output logic [31:0]       inst_out,
  output logic [31:0]       inst_pc,
  output logic              flush
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        flush_q, flush_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_dat_q, skid_dat_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  pc_sel_e     pc_sel;
  logic        redirect;
  logic        req;

  pc_next u_pc_next (
    .pc          (pc_q),
    .jump_target (jump_target),
    .sel         (pc_sel),
    .pc_nxt      (pc_d)
  );

  // A held live instruction under stall suppresses new requests.
  assign redirect = pc_jump && (state_q != ST_IDLE);
  assign req      = (state_q == ST_FETCH) && !(stall && inst_valid_q);

  always_comb begin
    state_d      = state_q;
    pc_sel       = PC_HOLD;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    flush_d      = redirect;
    skid_vld_d   = skid_vld_q;
    skid_dat_d   = skid_dat_q;
    skid_pc_d    = skid_pc_q;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        if (redirect)
          state_d = req ? ST_DISCARD : ST_FETCH;
        else if (req)
          state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (redirect) begin
          state_d = imem.imem_rvalid ? ST_FETCH : ST_DISCARD;
        end else if (imem.imem_rvalid) begin
          pc_sel = PC_INC;
          if (stall && inst_valid_q) begin
            skid_vld_d = 1'b1;
            skid_dat_d = imem.imem_rdata;
            skid_pc_d  = pc_q;
            state_d    = ST_HOLD;
          end else begin
            inst_valid_d = 1'b1;
            inst_out_d   = imem.imem_rdata;
            inst_pc_d    = pc_q;
            state_d      = ST_FETCH;
          end
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_FETCH;
        end else if (!stall) begin
          inst_valid_d = skid_vld_q;
          inst_out_d   = skid_dat_q;
          inst_pc_d    = skid_pc_q;
          skid_vld_d   = 1'b0;
          state_d      = ST_FETCH;
        end
      end

      // The response to the abandoned request is swallowed whether or not another redirect lands.
      ST_DISCARD: begin
        if (imem.imem_rvalid)
          state_d = ST_FETCH;
      end

      default: state_d = ST_IDLE;
    endcase

    if (redirect) begin
      pc_sel       = PC_JUMP;
      inst_valid_d = 1'b0;
      skid_vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_VECTOR;
      inst_valid_q <= 1'b0;
      inst_out_q   <= NOP_INST;
      inst_pc_q    <= 32'h0000_0000;
      flush_q      <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_dat_q   <= NOP_INST;
      skid_pc_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      flush_q      <= flush_d;
      skid_vld_q   <= skid_vld_d;
      skid_dat_q   <= skid_dat_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst_out       = inst_out_q;
  assign inst_pc        = inst_pc_q;
  assign flush          = flush_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: per-cycle vector table with a scoreboard on delivered instructions,
// plus a second instance with RESET_VECTOR at the top of the address space.
module tb_pc_fetch;

  logic        clk;
  logic        rst_n, rst2_n;
  logic        stall, pc_jump;
  logic [31:0] jump_target;
  logic        inst_valid, flush;
  logic [31:0] inst_out, inst_pc;

  logic        stall2, pc_jump2;
  logic [31:0] jump_target2;
  logic        inst_valid2, flush2;
  logic [31:0] inst_out2, inst_pc2;

  pc_fetch_if imem1 ();
  pc_fetch_if imem2 ();

  pc_fetch u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem1),
    .pc_jump     (pc_jump),
    .jump_target (jump_target),
    .stall       (stall),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .flush       (flush)
  );

  pc_fetch #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut_top (
    .clk         (clk),
    .rst_n       (rst2_n),
    .imem        (imem2),
    .pc_jump     (pc_jump2),
    .jump_target (jump_target2),
    .stall       (stall2),
    .inst_valid  (inst_valid2),
    .inst_out    (inst_out2),
    .inst_pc     (inst_pc2),
    .flush       (flush2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  // Scoreboard: {inst_pc, inst_out} pushed when the response is driven.
  logic [63:0] sb_q[$];
  logic        prev_v   = 1'b0;
  logic [31:0] prev_pc  = 32'h0;
  logic [31:0] prev_out = 32'h0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (inst_valid && (!prev_v || inst_pc != prev_pc || inst_out != prev_out)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc %h inst %h with nothing expected", inst_pc, inst_out);
      end else begin
        e = sb_q.pop_front();
        if ({inst_pc, inst_out} !== e) begin
          errors++;
          $display("FAIL sb_inst: got pc %h inst %h expected pc %h inst %h",
                   inst_pc, inst_out, e[63:32], e[31:0]);
        end
      end
    end
    prev_v   = inst_valid;
    prev_pc  = inst_pc;
    prev_out = inst_out;
  end

  typedef struct {
    logic        rst;
    logic        st;
    logic        pj;
    logic [31:0] tgt;
    logic        rv;
    logic [31:0] rd;
    logic        push;
    logic        er;
    logic [31:0] ea;
    logic        ev;
    logic [31:0] eipc;
    logic [31:0] eout;
    logic        ef;
  } vec_t;

  function automatic vec_t v(logic rst, logic st, logic pj, logic [31:0] tgt, logic rv,
                             logic [31:0] rd, logic push, logic er, logic [31:0] ea, logic ev,
                             logic [31:0] eipc, logic [31:0] eout, logic ef);
    vec_t r;
    r.rst = rst; r.st = st; r.pj = pj; r.tgt = tgt; r.rv = rv; r.rd = rd; r.push = push;
    r.er = er; r.ea = ea; r.ev = ev; r.eipc = eipc; r.eout = eout; r.ef = ef;
    return r;
  endfunction

  localparam int NV = 41;
  vec_t tv[NV];

  initial begin
    //          rst st pj tgt     rv rd      push req addr    vld ipc     out     fl
    tv[0]  = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h000, 0, 32'h000, 32'h13, 0);
    tv[1]  = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h000, 0, 32'h000, 32'h13, 0);
    tv[2]  = v(1, 0, 0, 32'h0,   1, 32'h11,  1, 0, 32'h000, 0, 32'h000, 32'h13, 0);
    tv[3]  = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h004, 1, 32'h000, 32'h11, 0);
    tv[4]  = v(1, 0, 0, 32'h0,   1, 32'h22,  1, 0, 32'h004, 1, 32'h000, 32'h11, 0);
    tv[5]  = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h008, 1, 32'h004, 32'h22, 0);
    tv[6]  = v(1, 0, 0, 32'h0,   1, 32'h33,  1, 0, 32'h008, 1, 32'h004, 32'h22, 0);
    tv[7]  = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h00C, 1, 32'h008, 32'h33, 0);
    tv[8]  = v(1, 0, 1, 32'h103, 0, 32'h0,   0, 0, 32'h00C, 1, 32'h008, 32'h33, 0);
    tv[9]  = v(1, 0, 0, 32'h0,   1, 32'hDEAD,0, 0, 32'h100, 0, 32'h008, 32'h33, 1);
    tv[10] = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h100, 0, 32'h008, 32'h33, 0);
    tv[11] = v(1, 0, 0, 32'h0,   1, 32'h44,  1, 0, 32'h100, 0, 32'h008, 32'h33, 0);
    tv[12] = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h104, 1, 32'h100, 32'h44, 0);
    tv[13] = v(1, 1, 0, 32'h0,   1, 32'h55,  1, 0, 32'h104, 1, 32'h100, 32'h44, 0);
    tv[14] = v(1, 1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h108, 1, 32'h100, 32'h44, 0);
    tv[15] = v(1, 1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h108, 1, 32'h100, 32'h44, 0);
    tv[16] = v(1, 1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h108, 1, 32'h100, 32'h44, 0);
    tv[17] = v(1, 1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h108, 1, 32'h100, 32'h44, 0);
    tv[18] = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h108, 1, 32'h100, 32'h44, 0);
    tv[19] = v(1, 1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h108, 1, 32'h104, 32'h55, 0);
    tv[20] = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h108, 1, 32'h104, 32'h55, 0);
    tv[21] = v(1, 0, 1, 32'h200, 1, 32'h66,  0, 0, 32'h108, 1, 32'h104, 32'h55, 0);
    tv[22] = v(1, 0, 1, 32'h300, 0, 32'h0,   0, 1, 32'h200, 0, 32'h104, 32'h55, 1);
    tv[23] = v(1, 0, 1, 32'h404, 0, 32'h0,   0, 0, 32'h300, 0, 32'h104, 32'h55, 1);
    tv[24] = v(1, 0, 0, 32'h0,   1, 32'h77,  0, 0, 32'h404, 0, 32'h104, 32'h55, 1);
    tv[25] = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h404, 0, 32'h104, 32'h55, 0);
    tv[26] = v(1, 0, 0, 32'h0,   1, 32'h88,  1, 0, 32'h404, 0, 32'h104, 32'h55, 0);
    tv[27] = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h408, 1, 32'h404, 32'h88, 0);
    tv[28] = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h408, 1, 32'h404, 32'h88, 0);
    tv[29] = v(0, 0, 0, 32'h0,   1, 32'hBAD, 0, 0, 32'h000, 0, 32'h000, 32'h13, 0);
    tv[30] = v(0, 0, 0, 32'h0,   1, 32'hBAD, 0, 0, 32'h000, 0, 32'h000, 32'h13, 0);
    tv[31] = v(1, 0, 0, 32'h0,   1, 32'hBAD, 0, 0, 32'h000, 0, 32'h000, 32'h13, 0);
    tv[32] = v(1, 1, 0, 32'h0,   0, 32'h0,   0, 1, 32'h000, 0, 32'h000, 32'h13, 0);
    tv[33] = v(1, 1, 0, 32'h0,   1, 32'h99,  1, 0, 32'h000, 0, 32'h000, 32'h13, 0);
    tv[34] = v(1, 1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h004, 1, 32'h000, 32'h99, 0);
    tv[35] = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h004, 1, 32'h000, 32'h99, 0);
    tv[36] = v(1, 1, 0, 32'h0,   1, 32'hA1,  0, 0, 32'h004, 1, 32'h000, 32'h99, 0);
    tv[37] = v(1, 1, 1, 32'h500, 0, 32'h0,   0, 0, 32'h008, 1, 32'h000, 32'h99, 0);
    tv[38] = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h500, 0, 32'h000, 32'h99, 1);
    tv[39] = v(1, 0, 0, 32'h0,   1, 32'hB2,  1, 0, 32'h500, 0, 32'h000, 32'h99, 0);
    tv[40] = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h504, 1, 32'h500, 32'hB2, 0);

    rst_n = 1'b0; rst2_n = 1'b0;
    stall = 1'b0; pc_jump = 1'b0; jump_target = 32'h0;
    stall2 = 1'b0; pc_jump2 = 1'b0; jump_target2 = 32'h0;
    imem1.imem_rvalid = 1'b0; imem1.imem_rdata = 32'h0;
    imem2.imem_rvalid = 1'b0; imem2.imem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   -1, {31'b0, imem1.imem_req}, 32'h0);
    chk("rst_addr",  -1, imem1.imem_addr, 32'h0);
    chk("rst_valid", -1, {31'b0, inst_valid}, 32'h0);
    chk("rst_out",   -1, inst_out, 32'h0000_0013);
    chk("rst_ipc",   -1, inst_pc, 32'h0);
    chk("rst_flush", -1, {31'b0, flush}, 32'h0);
    chk("rst2_addr", -1, imem2.imem_addr, 32'hFFFF_FFFC);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n             = tv[i].rst;
      stall             = tv[i].st;
      pc_jump           = tv[i].pj;
      jump_target       = tv[i].tgt;
      imem1.imem_rvalid = tv[i].rv;
      imem1.imem_rdata  = tv[i].rd;
      if (tv[i].push) sb_q.push_back({tv[i].ea, tv[i].rd});
      #1;
      chk("imem_req",   i, {31'b0, imem1.imem_req}, {31'b0, tv[i].er});
      chk("imem_addr",  i, imem1.imem_addr, tv[i].ea);
      chk("inst_valid", i, {31'b0, inst_valid}, {31'b0, tv[i].ev});
      chk("inst_pc",    i, inst_pc, tv[i].eipc);
      chk("inst_out",   i, inst_out, tv[i].eout);
      chk("flush",      i, {31'b0, flush}, {31'b0, tv[i].ef});
    end
    @(negedge clk);
    imem1.imem_rvalid = 1'b0;
    #1;
    chk("sb_drained", NV, sb_q.size(), 32'd0);

    // Top-of-memory reset vector: the sequential fetch after 0xFFFF_FFFC wraps to 0.
    @(negedge clk); rst2_n = 1'b1; #1;
    chk("wrap_idle_req", 0, {31'b0, imem2.imem_req}, 32'h0);
    chk("wrap_idle_addr", 0, imem2.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_fetch_req", 1, {31'b0, imem2.imem_req}, 32'h1);
    chk("wrap_fetch_addr", 1, imem2.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); imem2.imem_rvalid = 1'b1; imem2.imem_rdata = 32'hAB; #1;
    chk("wrap_wait_req", 2, {31'b0, imem2.imem_req}, 32'h0);
    @(negedge clk); imem2.imem_rvalid = 1'b0; #1;
    chk("wrap_req2",  3, {31'b0, imem2.imem_req}, 32'h1);
    chk("wrap_addr2", 3, imem2.imem_addr, 32'h0000_0000);
    chk("wrap_valid", 3, {31'b0, inst_valid2}, 32'h1);
    chk("wrap_ipc",   3, inst_pc2, 32'hFFFF_FFFC);
    chk("wrap_out",   3, inst_out2, 32'hAB);
    chk("wrap_flush", 3, {31'b0, flush2}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
